// File: rtl/mem_store_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buf_pkg
// Description : Store-size encodings and byte-mask base constants for the
//               memory-stage store buffer.
// Revision    : 1.0 - initial release
// ============================================================================

package mem_store_buf_pkg;

  typedef enum logic [1:0] {
    SZ_SB = 2'd0,
    SZ_SH = 2'd1,
    SZ_SW = 2'd2,
    SZ_SD = 2'd3
  } st_size_e;

  localparam logic [7:0] c_mask_sb = 8'h01;
  localparam logic [7:0] c_mask_sh = 8'h03;
  localparam logic [7:0] c_mask_sw = 8'h0F;
  localparam logic [7:0] c_mask_sd = 8'hFF;

  // Byte-enable pattern for an access of the given size at lane 0.
  function automatic logic [7:0] size_mask(input st_size_e sz);
    logic [7:0] m;
    case (sz)
      SZ_SB:   m = c_mask_sb;
      SZ_SH:   m = c_mask_sh;
      SZ_SW:   m = c_mask_sw;
      default: m = c_mask_sd;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_store_buf_store_align.sv
`default_nettype none
// ============================================================================
// Module      : store_align
// Description : Combinational alignment check, byte-mask generation and
//               lane shift for an incoming store.
// Revision    : 1.0 - initial release
// ============================================================================

module store_align
  import mem_store_buf_pkg::*;
#(
  parameter int CPU_WIDTH = 64
) (
  input  logic [CPU_WIDTH-1:0] addr,
  input  logic [CPU_WIDTH-1:0] data,
  input  logic [1:0]           size,
  output logic                 aligned,
  output logic [CPU_WIDTH-1:0] waddr,
  output logic [63:0]          wdata,
  output logic [7:0]           mask
);

  logic [2:0]  w_off;
  logic [63:0] w_data64;
  st_size_e    w_size;

  assign w_off    = addr[2:0];
  assign w_size   = st_size_e'(size);
  assign w_data64 = 64'(data);

  always_comb begin
    aligned = 1'b1;
    case (w_size)
      SZ_SH:   aligned = (w_off[0] == 1'b0);
      SZ_SW:   aligned = (w_off[1:0] == 2'b00);
      SZ_SD:   aligned = (w_off == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  // Bytes shifted past lane 7 fall off; a misaligned request never lands anyway.
  assign mask  = size_mask(w_size) << w_off;
  assign wdata = w_data64 << {w_off, 3'b000};
  assign waddr = {addr[CPU_WIDTH-1:3], 3'b000};

endmodule

`default_nettype wire

// File: rtl/mem_store_buf.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buf
// Description : In-order store queue between the memory stage and the data
//               memory write port, with load-address conflict detection.
// Revision    : 1.0 - initial release
// ============================================================================

module mem_store_buf
  import mem_store_buf_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CPU_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [CPU_WIDTH-1:0] st_addr,
  input  logic [CPU_WIDTH-1:0] st_data,
  input  logic [1:0]           st_size,
  output logic                 st_err,
  output logic                 mem_wvalid,
  input  logic                 mem_wready,
  output logic [CPU_WIDTH-1:0] mem_waddr,
  output logic [63:0]          mem_wdata,
  output logic [7:0]           mem_wmask,
  input  logic [CPU_WIDTH-1:0] ld_chk_addr,
  output logic                 ld_conflict,
  output logic                 drained
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [DEPTH-1:0]     r_valid;
  logic                 r_st_err;

  logic [CPU_WIDTH-1:0] r_waddr [DEPTH];
  logic [63:0]          r_wdata [DEPTH];
  logic [7:0]           r_wmask [DEPTH];

  logic                 w_aligned;
  logic [CPU_WIDTH-1:0] w_waddr;
  logic [63:0]          w_wdata;
  logic [7:0]           w_wmask;
  logic                 w_req;
  logic                 w_push;
  logic                 w_pop;
  logic [DEPTH-1:0]     w_match;
  logic                 w_unused;

  store_align #(
    .CPU_WIDTH(CPU_WIDTH)
  ) u_store_align (
    .addr    (st_addr),
    .data    (st_data),
    .size    (st_size),
    .aligned (w_aligned),
    .waddr   (w_waddr),
    .wdata   (w_wdata),
    .mask    (w_wmask)
  );

  assign st_ready   = (r_count != c_full);
  assign w_req      = st_valid & st_ready;
  assign w_push     = w_req & w_aligned;
  assign mem_wvalid = (r_count != '0);
  assign w_pop      = mem_wvalid & mem_wready;
  assign drained    = (r_count == '0);
  assign st_err     = r_st_err;

  assign mem_waddr  = r_waddr[r_head];
  assign mem_wdata  = r_wdata[r_head];
  assign mem_wmask  = r_wmask[r_head];

  assign w_unused   = &{1'b0, ld_chk_addr[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_st_err <= 1'b0;
    end else begin
      r_st_err <= w_req & ~w_aligned;
      if (w_push) begin
        r_tail          <= r_tail + PTR_W'(1);
        r_valid[r_tail] <= 1'b1;
      end
      // head == tail with both push and pop cannot occur: that needs empty and full at once
      if (w_pop) begin
        r_head          <= r_head + PTR_W'(1);
        r_valid[r_head] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[r_tail] <= w_waddr;
      r_wdata[r_tail] <= w_wdata;
      r_wmask[r_tail] <= w_wmask;
    end
  end

  // Doubleword-granular match against entries already in the queue only.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_match[gi] = r_valid[gi] &&
                           (r_waddr[gi][CPU_WIDTH-1:3] == ld_chk_addr[CPU_WIDTH-1:3]);
    end
  endgenerate

  assign ld_conflict = |w_match;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_store_buf
// Description : Directed self-checking bench for mem_store_buf.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_store_buf;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        st_err;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] ld_chk_addr;
  logic        ld_conflict;
  logic        drained;

  int n_tests = 0;
  int n_fail  = 0;

  mem_store_buf #(.DEPTH(4), .CPU_WIDTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_err      (st_err),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .ld_chk_addr (ld_chk_addr),
    .ld_conflict (ld_conflict),
    .drained     (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hDEAD0000 + 32'(i), 32'h0000BEE0 + 32'(i)};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
    n_tests++; if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_drained: got %b want 1", drained); end
    n_tests++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b want 0", mem_wvalid); end
    n_tests++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL reset_st_err: got %b want 0", st_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sb();
    mem_wready = 1'b1;
    st_valid = 1'b1; st_addr = 64'h80000005; st_data = 64'hAB; st_size = 2'd0;
    #1;
    n_tests++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL sb_no_bypass: got %b want 0", mem_wvalid); end
    tick();
    st_valid = 1'b0;
    n_tests++; if (mem_wvalid !== 1'b1) begin n_fail++; $display("FAIL sb_wvalid: got %b want 1", mem_wvalid); end
    n_tests++; if (mem_waddr !== 64'h80000000) begin n_fail++; $display("FAIL sb_waddr: got %h want 80000000", mem_waddr); end
    n_tests++; if (mem_wmask !== 8'h20) begin n_fail++; $display("FAIL sb_wmask: got %h want 20", mem_wmask); end
    n_tests++; if (mem_wdata !== 64'h0000AB0000000000) begin n_fail++; $display("FAIL sb_wdata: got %h want 0000ab0000000000", mem_wdata); end
    tick();
    n_tests++; if (drained !== 1'b1) begin n_fail++; $display("FAIL sb_drained: got %b want 1", drained); end
  endtask

  task automatic test_sw();
    mem_wready = 1'b1;
    st_valid = 1'b1; st_addr = 64'h80000004; st_data = 64'h12345678; st_size = 2'd2;
    tick();
    st_valid = 1'b0;
    n_tests++; if (mem_wmask !== 8'hF0) begin n_fail++; $display("FAIL sw_wmask: got %h want f0", mem_wmask); end
    n_tests++; if (mem_wdata !== 64'h1234567800000000) begin n_fail++; $display("FAIL sw_wdata: got %h want 1234567800000000", mem_wdata); end
    n_tests++; if (mem_waddr !== 64'h80000000) begin n_fail++; $display("FAIL sw_waddr: got %h want 80000000", mem_waddr); end
    tick();
  endtask

  task automatic test_misalign();
    mem_wready = 1'b1;
    st_valid = 1'b1; st_addr = 64'h80000003; st_data = 64'h5555; st_size = 2'd1;
    tick();
    st_valid = 1'b0;
    n_tests++; if (st_err !== 1'b1) begin n_fail++; $display("FAIL mis_err_pulse: got %b want 1", st_err); end
    n_tests++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL mis_wvalid: got %b want 0", mem_wvalid); end
    n_tests++; if (drained !== 1'b1) begin n_fail++; $display("FAIL mis_drained: got %b want 1", drained); end
    tick();
    n_tests++; if (st_err !== 1'b0) begin n_fail++; $display("FAIL mis_err_once: got %b want 0", st_err); end
  endtask

  task automatic test_backpressure();
    mem_wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st_valid = 1'b1; st_addr = 64'h80001000 + 64'(8 * i); st_data = pat(i); st_size = 2'd3;
      #1;
      n_tests++;
      if (st_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want %b", i, st_ready, (i < 4)); end
      tick();
    end
    st_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (mem_wvalid !== 1'b1 || mem_waddr !== 64'h80001000 || mem_wdata !== pat(0) || mem_wmask !== 8'hFF) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b a=%h d=%h m=%h want v=1 a=80001000 d=%h m=ff", c, mem_wvalid, mem_waddr, mem_wdata, mem_wmask, pat(0));
      end
      tick();
    end
    mem_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (mem_wvalid !== 1'b1 || mem_waddr !== 64'h80001000 + 64'(8 * i) || mem_wdata !== pat(i)) begin
        n_fail++;
        $display("FAIL bp_order_%0d: got v=%b a=%h d=%h want v=1 a=%h d=%h", i, mem_wvalid, mem_waddr, mem_wdata, 64'h80001000 + 64'(8 * i), pat(i));
      end
      tick();
    end
    n_tests++; if (drained !== 1'b1) begin n_fail++; $display("FAIL bp_drained: got %b want 1", drained); end
  endtask

  task automatic test_conflict();
    mem_wready = 1'b0;
    st_valid = 1'b1; st_addr = 64'h80000008; st_data = 64'h77; st_size = 2'd3;
    ld_chk_addr = 64'h80000008;
    #1;
    n_tests++; if (ld_conflict !== 1'b0) begin n_fail++; $display("FAIL cf_inflight: got %b want 0", ld_conflict); end
    tick();
    st_valid = 1'b0;
    ld_chk_addr = 64'h8000000C; #1;
    n_tests++; if (ld_conflict !== 1'b1) begin n_fail++; $display("FAIL cf_same_dw: got %b want 1", ld_conflict); end
    ld_chk_addr = 64'h80000010; #1;
    n_tests++; if (ld_conflict !== 1'b0) begin n_fail++; $display("FAIL cf_next_dw: got %b want 0", ld_conflict); end
    mem_wready = 1'b1;
    tick();
    ld_chk_addr = 64'h80000008; #1;
    n_tests++; if (ld_conflict !== 1'b0) begin n_fail++; $display("FAIL cf_after_pop: got %b want 0", ld_conflict); end
  endtask

  task automatic test_full_push_pop();
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 64'h90000000 + 64'(8 * i); st_data = pat(10 + i); st_size = 2'd3;
      tick();
    end
    // full: pop happens, the offered push must not
    st_addr = 64'h90000100; st_data = pat(20); mem_wready = 1'b1;
    tick();
    st_valid = 1'b0; mem_wready = 1'b0;
    n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL fp_ready: got %b want 1", st_ready); end
    n_tests++; if (mem_waddr !== 64'h90000008) begin n_fail++; $display("FAIL fp_head: got %h want 90000008", mem_waddr); end
    st_valid = 1'b1; st_addr = 64'h90000200; st_data = pat(30); mem_wready = 1'b1;
    tick();
    st_valid = 1'b0; mem_wready = 1'b0;
    n_tests++; if (st_ready !== 1'b1 || mem_waddr !== 64'h90000010) begin n_fail++; $display("FAIL pp_same_cycle: got r=%b a=%h want r=1 a=90000010", st_ready, mem_waddr); end
    mem_wready = 1'b1;
    n_tests++; if (mem_waddr !== 64'h90000010 || mem_wdata !== pat(12)) begin n_fail++; $display("FAIL wrap_0: got a=%h d=%h want a=90000010 d=%h", mem_waddr, mem_wdata, pat(12)); end
    tick();
    n_tests++; if (mem_waddr !== 64'h90000018 || mem_wdata !== pat(13)) begin n_fail++; $display("FAIL wrap_1: got a=%h d=%h want a=90000018 d=%h", mem_waddr, mem_wdata, pat(13)); end
    tick();
    n_tests++; if (mem_waddr !== 64'h90000200 || mem_wdata !== pat(30)) begin n_fail++; $display("FAIL wrap_2: got a=%h d=%h want a=90000200 d=%h", mem_waddr, mem_wdata, pat(30)); end
    tick();
    n_tests++; if (drained !== 1'b1) begin n_fail++; $display("FAIL wrap_drained: got %b want 1", drained); end
  endtask

  task automatic test_async_reset();
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 64'hA0000000 + 64'(8 * i); st_data = pat(40 + i); st_size = 2'd3;
      tick();
    end
    st_valid = 1'b0;
    n_tests++; if (mem_wvalid !== 1'b1) begin n_fail++; $display("FAIL ar_pending: got %b want 1", mem_wvalid); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL ar_wvalid_now: got %b want 0", mem_wvalid); end
    n_tests++; if (drained !== 1'b1 || st_ready !== 1'b1) begin n_fail++; $display("FAIL ar_flags: got drained=%b ready=%b want 1 1", drained, st_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mem_wready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL ar_no_write_%0d: got %b want 0", c, mem_wvalid); end
    end
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'd0;
    mem_wready = 1'b0; ld_chk_addr = '0;
    test_reset();
    test_sb();
    test_sw();
    test_misalign();
    test_backpressure();
    test_conflict();
    test_full_push_pop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
